// File: rtl/uart_word_frame_buffer.sv
// uart_word_frame_buffer: receives a frame of bytes over a UART line, packs them
// little-endian into WORD_BYTES-wide words in a single-port RAM, hands the RAM to
// an external datapath (ready=1), and on start streams a separately sized frame
// back out over the UART, LSB byte first, ascending word address.
//
// Optional feature macro: RX_TIMEOUT_EN
//   Defined   -> idle counter in RX; a stalled partial frame is discarded after
//                TIMEOUT_CYCLES idle clocks and rx_timeout pulses for one cycle.
//   Undefined -> no counter, rx_timeout tied to 0, RX waits indefinitely.
//
// Ports (top):
//   clk, reset           clock, synchronous active-high reset
//   UART_TX / UART_RX    serial transmit / receive lines
//   rx_len / tx_len      frame lengths in words (0 or >DEPTH means DEPTH)
//   addr, writeEnable,
//   dataIn, dataOut      external RAM port, honoured only while ready=1;
//                        dataOut has one cycle of read latency
//   start                begin transmit (while ready=1)
//   ready                1 exactly in IDLE
//   rx_timeout           1-cycle pulse when a partial frame is discarded
//
// Also contains the uart core (8N1, CLKS_PER_BIT clocks per bit):
//   rx_line/tx_line serial pins, rx_data/rx_valid received byte strobe,
//   tx_ready idle flag, tx_data/tx_transmit one-cycle send request.

module uart #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_line,
    output logic       tx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_transmit
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_MID = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic {TxIdle, TxBusy} tx_state_e;

    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid_d;
    logic [1:0]      rx_sync_q;
    logic            rx_in;

    tx_state_e       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [9:0]      tx_frame_q, tx_frame_d;

    assign rx_in = rx_sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_sync_q  <= 2'b11;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_frame_q <= '1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_sync_q  <= {rx_sync_q[0], rx_line};
            rx_valid   <= rx_valid_d;
            if (rx_valid_d) begin
                rx_data <= rx_shift_q;
            end
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_frame_q <= tx_frame_d;
        end
    end

    // Receiver: confirm the start bit at mid-bit, then sample every full bit period.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (!rx_in) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == BIT_MID) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_in ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_in, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    rx_valid_d = rx_in;  // framing error drops the byte
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // Transmitter: 10-bit frame {stop, data, start} shifted out LSB first.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_frame_d = tx_frame_q;
        case (tx_state_q)
            TxIdle: begin
                if (tx_transmit) begin
                    tx_frame_d = {1'b1, tx_data, 1'b0};
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TxBusy;
                end
            end
            TxBusy: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_frame_d = {1'b1, tx_frame_q[9:1]};
                    if (tx_bit_q == 4'd9) begin
                        tx_state_d = TxIdle;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    assign tx_line  = (tx_state_q == TxBusy) ? tx_frame_q[0] : 1'b1;
    assign tx_ready = (tx_state_q == TxIdle);
endmodule

module uart_word_frame_buffer #(
    parameter int unsigned DEPTH          = 64,
    parameter int unsigned ADDR_BITS      = 6,
    parameter int unsigned WORD_BYTES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CLKS_PER_BIT   = 868
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      UART_TX,
    input  logic                      UART_RX,
    input  logic [ADDR_BITS:0]        rx_len,
    input  logic [ADDR_BITS:0]        tx_len,
    input  logic [ADDR_BITS-1:0]      addr,
    input  logic                      writeEnable,
    input  logic [8*WORD_BYTES-1:0]   dataIn,
    output logic [8*WORD_BYTES-1:0]   dataOut,
    input  logic                      start,
    output logic                      ready,
    output logic                      rx_timeout
);
    localparam int unsigned W        = 8 * WORD_BYTES;
    localparam int unsigned CNT_BITS = $clog2(WORD_BYTES) + 1;
    localparam logic [ADDR_BITS:0]  DEPTH_LEN = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]  LEN_ONE   = (ADDR_BITS + 1)'(1);
    localparam logic [CNT_BITS-1:0] CNT_LAST  = CNT_BITS'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        StPrepRx, StRx, StIdle, StPrepTx, StTxLoad, StTxLatch, StTxWait, StTxSend
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [ADDR_BITS:0]    len_q, len_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [W-1:0]          asm_q, asm_d, asm_next;
    logic [W-1:0]          shift_q, shift_d;
    logic                  word_we;
    logic                  last_word;

    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  tx_ready;
    logic [7:0]            tx_data;
    logic                  tx_transmit;

    logic [W-1:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0]  ram_addr;
    logic                  ram_we;
    logic [W-1:0]          ram_wdata;

    uart #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk        (clk),
        .reset      (reset),
        .rx_line    (UART_RX),
        .tx_line    (UART_TX),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_transmit(tx_transmit)
    );

    function automatic logic [ADDR_BITS:0] clamp_len(input logic [ADDR_BITS:0] l);
        if (l == '0 || l > DEPTH_LEN) begin
            return DEPTH_LEN;
        end
        return l;
    endfunction

    // New byte enters at the top so the first byte of a word ends up in [7:0].
    assign asm_next  = (asm_q >> 8) | (W'(rx_data) << (W - 8));
    assign last_word = ({1'b0, addr_q} == (len_q - LEN_ONE));
    assign ready     = (state_q == StIdle);

    // External side owns the RAM only in IDLE.
    always_comb begin
        if (state_q == StIdle) begin
            ram_addr  = addr;
            ram_we    = writeEnable;
            ram_wdata = dataIn;
        end else begin
            ram_addr  = addr_q;
            ram_we    = word_we;
            ram_wdata = asm_next;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        dataOut <= mem[ram_addr];
    end

`ifdef RX_TIMEOUT_EN
    localparam int unsigned TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

    logic [TO_BITS-1:0] idle_cnt_q;
    logic               rx_started_q;
    logic               rx_timeout_q;
    logic               timeout_hit;

    // Counter only runs once the current frame has received its first byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q   <= '0;
            rx_started_q <= 1'b0;
            rx_timeout_q <= 1'b0;
        end else begin
            rx_timeout_q <= timeout_hit;
            if (state_q != StRx) begin
                idle_cnt_q   <= '0;
                rx_started_q <= 1'b0;
            end else if (rx_valid) begin
                idle_cnt_q   <= '0;
                rx_started_q <= 1'b1;
            end else if (rx_started_q) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
        end
    end

    assign rx_timeout = rx_timeout_q;
`else
    assign rx_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StPrepRx;
            addr_q  <= '0;
            len_q   <= DEPTH_LEN;
            cnt_q   <= '0;
            asm_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        shift_d     = shift_q;
        word_we     = 1'b0;
        tx_transmit = 1'b0;
        tx_data     = shift_q[7:0];
`ifdef RX_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_q)
            StPrepRx: begin
                len_d   = clamp_len(rx_len);
                addr_d  = '0;
                cnt_d   = '0;
                asm_d   = '0;
                state_d = StRx;
            end
            StRx: begin
                if (rx_valid) begin
                    asm_d = asm_next;
                    if (cnt_q == CNT_LAST) begin
                        word_we = 1'b1;
                        cnt_d   = '0;
                        addr_d  = addr_q + 1'b1;
                        if (last_word) begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef RX_TIMEOUT_EN
                // PREP_RX resets address and byte count, dropping the partial frame.
                else if (rx_started_q && idle_cnt_q == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = StPrepRx;
                end
`endif
            end
            StIdle: begin
                if (start) begin
                    state_d = StPrepTx;
                end
            end
            StPrepTx: begin
                len_d   = clamp_len(tx_len);
                addr_d  = '0;
                state_d = StTxLoad;
            end
            StTxLoad: begin
                state_d = StTxLatch;
            end
            StTxLatch: begin
                shift_d = dataOut;
                cnt_d   = '0;
                state_d = StTxWait;
            end
            StTxWait: begin
                if (tx_ready) begin
                    state_d = StTxSend;
                end
            end
            StTxSend: begin
                tx_transmit = 1'b1;
                shift_d     = shift_q >> 8;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q != CNT_LAST) begin
                    state_d = StTxWait;
                end else if (last_word) begin
                    state_d = StPrepRx;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = StTxLoad;
                end
            end
            default: state_d = StPrepRx;
        endcase
    end
endmodule

// File: tb/tb_uart_word_frame_buffer.sv
// Directed bench for uart_word_frame_buffer: drives UART_RX bytes, decodes
// UART_TX into a queue, and compares decoded bytes against an expected-byte
// scoreboard filled when each transmit is started.
module tb_uart_word_frame_buffer;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        UART_TX;
    logic        UART_RX;
    logic [6:0]  rx_len;
    logic [6:0]  tx_len;
    logic [5:0]  addr;
    logic        writeEnable;
    logic [15:0] dataIn;
    logic [15:0] dataOut;
    logic        start;
    logic        ready;
    logic        rx_timeout;

    int checks = 0;
    int errors = 0;
    logic [7:0] mon_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_word_frame_buffer #(
        .DEPTH(64),
        .ADDR_BITS(6),
        .WORD_BYTES(2),
        .TIMEOUT_CYCLES(1000),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .UART_TX    (UART_TX),
        .UART_RX    (UART_RX),
        .rx_len     (rx_len),
        .tx_len     (tx_len),
        .addr       (addr),
        .writeEnable(writeEnable),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .start      (start),
        .ready      (ready),
        .rx_timeout (rx_timeout)
    );

    // Serial monitor: sample each bit at its centre.
    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (UART_TX === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = UART_TX;
                end
                repeat (CPB) @(negedge clk);
                mon_q.push_back(b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        UART_RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (CPB) @(negedge clk);
        end
        UART_RX = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check(tag, ready, 1);
    endtask

    task automatic read_word(input logic [5:0] a, input logic [15:0] exp, input string tag);
        @(negedge clk);
        addr = a;
        @(negedge clk);
        check(tag, dataOut, exp);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ready_drop", ready, 0);
    endtask

    task automatic expect_tx(input int n, input string tag);
        int t = 0;
        while (mon_q.size() < n && t < n * CPB * 12 + 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_count"}, mon_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (mon_q.size() > 0 && exp_q.size() > 0) begin
                check(tag, mon_q.pop_front(), exp_q.pop_front());
            end
        end
    endtask

    initial begin : stim
        int t;
        int lows;
        int pulses;
        logic [15:0] w0;

        reset = 1'b1;
        UART_RX = 1'b1;
        rx_len = 7'd3;
        tx_len = 7'd2;
        addr = '0;
        writeEnable = 1'b0;
        dataIn = '0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", ready, 0);
        check("reset_timeout", rx_timeout, 0);
        check("reset_tx_idle", UART_TX, 1);
        reset = 1'b0;

        // 3-word frame, little-endian packing
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55);
        check("rx_partial_ready", ready, 0);
        send_byte(8'h66);
        wait_ready("rx_done_ready");
        read_word(6'd0, 16'h2211, "rd_addr0");
        read_word(6'd1, 16'h4433, "rd_addr1");
        read_word(6'd2, 16'h6655, "rd_addr2");

        // External write, then 2-word transmit with a stalled tx_ready
        @(negedge clk);
        addr = 6'd1;
        dataIn = 16'hBEEF;
        writeEnable = 1'b1;
        @(negedge clk);
        writeEnable = 1'b0;
        read_word(6'd1, 16'hBEEF, "ext_write");
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
        pulse_start();
        t = 0;
        while (mon_q.size() < 1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        force dut.tx_ready = 1'b0;
        lows = 0;
        repeat (500) begin
            @(negedge clk);
            if (UART_TX === 1'b0) lows++;
        end
        check("stall_line_idle", lows, 0);
        check("stall_byte_count", mon_q.size(), 1);
        release dut.tx_ready;
        expect_tx(4, "tx_frame");
        repeat (50) @(negedge clk);
        check("tx_no_extra", mon_q.size(), 0);
        check("tx_back_to_rx", ready, 0);

        // Back in RX expecting 3 words again
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        send_byte(8'hA4); send_byte(8'hA5);
        check("rx2_partial_ready", ready, 0);
        send_byte(8'hA6);
        wait_ready("rx2_done_ready");
        read_word(6'd0, 16'hA2A1, "rx2_addr0");

        // rx_len = 0 means DEPTH words
        rx_len = 7'd0;
        tx_len = 7'd1;
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        pulse_start();
        expect_tx(2, "tx_one_word_a");
        for (int i = 0; i < 127; i++) send_byte(8'(i));
        check("len0_partial_ready", ready, 0);
        send_byte(8'd127);
        wait_ready("len0_done_ready");
        read_word(6'd63, 16'h7F7E, "len0_addr63");
        read_word(6'd0, 16'h0100, "len0_addr0");

        // rx_len > DEPTH clamps to DEPTH
        rx_len = 7'd100;
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        pulse_start();
        expect_tx(2, "tx_one_word_b");
        for (int i = 0; i < 127; i++) send_byte(8'(i + 128));
        check("len100_partial_ready", ready, 0);
        send_byte(8'hFF);
        wait_ready("len100_done_ready");
        read_word(6'd63, 16'hFFFE, "len100_addr63");

        rx_len = 7'd3;
        exp_q.push_back(8'h80); exp_q.push_back(8'h81);
        pulse_start();
        expect_tx(2, "tx_one_word_c");

        // Stall mid-frame for longer than the timeout
        send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        pulses = 0;
        repeat (1200) begin
            @(negedge clk);
            if (rx_timeout === 1'b1) pulses++;
        end
`ifdef RX_TIMEOUT_EN
        check("timeout_pulses", pulses, 1);
        check("timeout_ready", ready, 0);
        send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3);
        send_byte(8'hD4); send_byte(8'hD5); send_byte(8'hD6);
        wait_ready("timeout_rx_ready");
        w0 = 16'hD2D1;
        read_word(6'd0, 16'hD2D1, "timeout_addr0");
        read_word(6'd1, 16'hD4D3, "timeout_addr1");
        read_word(6'd2, 16'hD6D5, "timeout_addr2");
`else
        check("no_timeout_pulses", pulses, 0);
        check("no_timeout_ready", ready, 0);
        send_byte(8'hC4); send_byte(8'hC5); send_byte(8'hC6);
        wait_ready("no_timeout_rx_ready");
        w0 = 16'hC2C1;
        read_word(6'd0, 16'hC2C1, "no_timeout_addr0");
        read_word(6'd1, 16'hC4C3, "no_timeout_addr1");
        read_word(6'd2, 16'hC6C5, "no_timeout_addr2");
`endif

        // Reset after 2 of 4 transmitted bytes
        tx_len = 7'd2;
        exp_q.push_back(w0[7:0]); exp_q.push_back(w0[15:8]);
        pulse_start();
        t = 0;
        while (mon_q.size() < 2 && t < 800) begin
            @(negedge clk);
            t++;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_tx_count", mon_q.size(), 2);
        for (int i = 0; i < 2; i++) begin
            if (mon_q.size() > 0 && exp_q.size() > 0) begin
                check("rst_tx_byte", mon_q.pop_front(), exp_q.pop_front());
            end
        end
        repeat (1000) @(negedge clk);
        check("rst_no_more_tx", mon_q.size(), 0);
        check("rst_ready", ready, 0);
        send_byte(8'hE1); send_byte(8'hE2); send_byte(8'hE3);
        send_byte(8'hE4); send_byte(8'hE5); send_byte(8'hE6);
        wait_ready("rst_rx_ready");
        read_word(6'd0, 16'hE2E1, "rst_addr0");
        read_word(6'd2, 16'hE6E5, "rst_addr2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
